// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, ROM address, IF/ID output register with valid/ready toward decode.
// Optional macro HALT_ON_ZERO_EN stops fetching at an all-zero instruction word.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_pc_plus8;
    logic [15:0] r_fetch_count;

    logic        w_advance;
    logic [31:0] w_pc_next;
    logic [31:0] w_target;

`ifdef HALT_ON_ZERO_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t r_state;
    logic   r_halted;
    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

    assign w_advance = !r_out_valid || out_ready;
    assign w_pc_next = (r_pc + 32'd4) & PC_MASK;
    // Word-align the redirect and fold it into the ROM address space.
    assign w_target  = branch_target & PC_MASK & ~32'h3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_out_valid    <= 1'b0;
            r_out_instr    <= 32'h0;
            r_out_pc       <= 32'h0;
            r_out_pc_plus8 <= 32'h8;
            r_fetch_count  <= 16'h0;
`ifdef HALT_ON_ZERO_EN
            r_state        <= RUN;
            r_halted       <= 1'b0;
`endif
        end else begin
            // A word flushed by a redirect is never counted as accepted.
            if (r_out_valid && out_ready && !branch_en && r_fetch_count != 16'hFFFF)
                r_fetch_count <= r_fetch_count + 16'd1;

            if (branch_en) begin
                r_pc        <= w_target;
                r_out_valid <= 1'b0;
`ifdef HALT_ON_ZERO_EN
                r_state     <= RUN;
                r_halted    <= 1'b0;
`endif
            end
`ifdef HALT_ON_ZERO_EN
            else if (r_state == HALT) begin
                if (out_ready)
                    r_out_valid <= 1'b0;
            end else if (w_advance && imem_rd == 32'h0) begin
                if (out_ready)
                    r_out_valid <= 1'b0;
                r_state  <= HALT;
                r_halted <= 1'b1;
            end
`endif
            else if (w_advance) begin
                r_out_instr    <= imem_rd;
                r_out_pc       <= r_pc;
                r_out_pc_plus8 <= r_pc + 32'd8;
                r_out_valid    <= 1'b1;
                r_pc           <= w_pc_next;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_pc       = r_out_pc;
    assign out_pc_plus8 = r_out_pc_plus8;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected words, a monitor pops on handshakes.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus8;
    logic        halted;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [64];
    logic [31:0] q_instr [$];
    logic [31:0] q_pc    [$];

    always #5 clk = ~clk;

    assign imem_rd = rom[imem_addr[7:2]];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus8 (out_pc_plus8),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        q_instr.push_back(instr);
        q_pc.push_back(pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes at the next rising edge.
    initial begin
        logic [31:0] ei, ep;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !branch_en) begin
                if (q_pc.size() == 0) begin
                    chk("unexpected_word_pc", out_pc, 32'hFFFF_FFFF);
                end else begin
                    ei = q_instr.pop_front();
                    ep = q_pc.pop_front();
                    chk("sb_instr", out_instr, ei);
                    chk("sb_pc", out_pc, ep);
                    chk("sb_pc_plus8", out_pc_plus8, ep + 32'd8);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + 32'(i);
        rom[0]  = 32'hE04F_000F;
        rom[1]  = 32'hE280_0002;
        rom[2]  = 32'hE3A0_A040;
        rom[10] = 32'hE281_1001;
        rom[63] = 32'h0000_0000;

        reset = 1'b1; out_ready = 1'b0; branch_en = 1'b0; branch_target = 32'h0;
        step();
        step();
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_plus8", out_pc_plus8, 32'h8);
        chk("rst_count", {16'b0, fetch_count}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);

        // Streaming with ready held high.
        push(32'hE04F_000F, 32'h0);
        push(32'hE280_0002, 32'h4);
        push(32'hE3A0_A040, 32'h8);
        reset = 1'b0; out_ready = 1'b1;
        step();
        chk("e1_valid", {31'b0, out_valid}, 32'h1);
        chk("e1_pc", out_pc, 32'h0);
        step();
        step();
        chk("e3_count", {16'b0, fetch_count}, 32'd2);
        chk("e3_pc", out_pc, 32'h8);
        chk("e3_plus8", out_pc_plus8, 32'h10);

        // Stall three cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", out_instr, 32'hE3A0_A040);
            chk("stall_addr", imem_addr, 32'hC);
            chk("stall_count", {16'b0, fetch_count}, 32'd2);
        end
        out_ready = 1'b1;
        step();
        chk("release_count", {16'b0, fetch_count}, 32'd3);
        chk("release_pc", out_pc, 32'hC);

        // Redirect while stalled.
        out_ready = 1'b0;
        step();
        chk("stall2_pc", out_pc, 32'hC);
        chk("stall2_addr", imem_addr, 32'h10);
        branch_en = 1'b1; branch_target = 32'h2B;
        step();
        chk("redir_valid", {31'b0, out_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h28);
        chk("redir_count", {16'b0, fetch_count}, 32'd3);
        branch_en = 1'b0; out_ready = 1'b1;
        push(32'hE281_1001, 32'h28);
        step();
        chk("redir_word_valid", {31'b0, out_valid}, 32'h1);
        chk("redir_word_pc", out_pc, 32'h28);
        chk("redir_word_instr", out_instr, 32'hE281_1001);
        step();
        chk("post_redir_count", {16'b0, fetch_count}, 32'd4);

        // Redirect with ready high: the presented word is flushed, not counted.
        branch_en = 1'b1; branch_target = 32'hFC;
        step();
        chk("flush_count", {16'b0, fetch_count}, 32'd4);
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_addr", imem_addr, 32'hFC);

`ifndef HALT_ON_ZERO_EN
        // Wrap past the last ROM word; the zero word is delivered normally.
        branch_en = 1'b0;
        push(32'h0, 32'hFC);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", out_pc, 32'hFC);
        chk("wrap_halted", {31'b0, halted}, 32'h0);
        step();
        chk("wrap_next_pc", out_pc, 32'h0);
        chk("wrap_next_instr", out_instr, 32'hE04F_000F);
        chk("wrap_count", {16'b0, fetch_count}, 32'd5);
        out_ready = 1'b0;
`else
        // Halt on the zero word at 0x34 after 13 deliveries.
        rom[13] = 32'h0;
        branch_target = 32'h0;
        step();
        branch_en = 1'b0;
        for (int i = 0; i < 13; i++) push(rom[i], 32'(i * 4));
        for (int i = 0; i < 40 && !halted; i++) step();
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_addr", imem_addr, 32'h34);
        chk("halt_valid", {31'b0, out_valid}, 32'h0);
        chk("halt_count", {16'b0, fetch_count}, 32'd17);
        step();
        chk("halt_frozen_addr", imem_addr, 32'h34);
        chk("halt_frozen_valid", {31'b0, out_valid}, 32'h0);
        branch_en = 1'b1; branch_target = 32'h0;
        step();
        chk("unhalt_flag", {31'b0, halted}, 32'h0);
        chk("unhalt_valid", {31'b0, out_valid}, 32'h0);
        branch_en = 1'b0;
        step();
        out_ready = 1'b0;
        chk("unhalt_instr", out_instr, 32'hE04F_000F);
        chk("unhalt_pc", out_pc, 32'h0);
`endif

        // Reset in the middle of a stall.
        step();
        chk("prerst_valid", {31'b0, out_valid}, 32'h1);
        reset = 1'b1;
        step();
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_count", {16'b0, fetch_count}, 32'h0);
        chk("midrst_halted", {31'b0, halted}, 32'h0);
        chk("midrst_plus8", out_pc_plus8, 32'h8);
        reset = 1'b0;
        step();
        chk("sb_drained", 32'(q_pc.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
